// File: rtl/vga_frame_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_frame_reader_if
//  Description : Read-only framebuffer port between the VGA frame reader
//                (master) and the data memory (slave). The memory answers
//                with rd_data during the cycle in which rd_en is high.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_frame_reader_if #(
  parameter int BUS = 32
);
  logic           rd_en;
  logic [BUS-1:0] rd_addr;
  logic [BUS-1:0] rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface
`default_nettype wire

// File: rtl/vga_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : vga_frame_reader
//  Description : Display-side framebuffer reader. Generates VGA raster timing,
//                fetches one 32-bit colour word per tile one pixel ahead of
//                use, and drives registered RGB plus active-low syncs.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_reader #(
  parameter int          BUS        = 32,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int          PIX_DIV    = 2,
  parameter int          TILE_SHIFT = 5,
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33
) (
  input  wire logic          clk,
  input  wire logic          reset,
  vga_frame_reader_if.master mem,
  output logic [7:0]         R,
  output logic [7:0]         G,
  output logic [7:0]         B,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_start
);

  // --------------------------------------------------------------------------
  // Derived geometry
  // --------------------------------------------------------------------------
  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_TILES_X = H_ACTIVE >> TILE_SHIFT;

  // Counter widths leave room for one value past the last position, because
  // the look-ahead column (h'+1) can reach H_TOTAL.
  localparam int c_HW = $clog2(c_H_TOTAL + 1);
  localparam int c_VW = $clog2(c_V_TOTAL + 1);
  localparam int c_DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(PIX_DIV - 1);

  localparam logic [c_HW-1:0] c_H_LAST   = c_HW'(c_H_TOTAL - 1);
  localparam logic [c_HW-1:0] c_H_RST    = c_HW'(c_H_TOTAL - 2);
  localparam logic [c_HW-1:0] c_H_ACT    = c_HW'(H_ACTIVE);
  localparam logic [c_HW-1:0] c_HS_BEG   = c_HW'(H_ACTIVE + H_FP);
  localparam logic [c_HW-1:0] c_HS_END   = c_HW'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [c_VW-1:0] c_V_LAST   = c_VW'(c_V_TOTAL - 1);
  localparam logic [c_VW-1:0] c_V_ACT    = c_VW'(V_ACTIVE);
  localparam logic [c_VW-1:0] c_VS_BEG   = c_VW'(V_ACTIVE + V_FP);
  localparam logic [c_VW-1:0] c_VS_END   = c_VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [BUS-1:0]  c_BASE     = BUS'(BASE_ADDR);
  localparam logic [BUS-1:0]  c_TX       = BUS'(c_TILES_X);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_DW-1:0] r_div;
  logic [c_HW-1:0] r_h;
  logic [c_VW-1:0] r_v;

  logic [23:0]     r_rgb;
  logic            r_hsync;
  logic            r_vsync;
  logic            r_frame_start;

  logic            r_rd_en;
  logic [BUS-1:0]  r_rd_addr;

  logic [23:0]     r_cur_tile;
  logic [23:0]     r_next_tile;

  // --------------------------------------------------------------------------
  // Next raster position and everything derived from it
  // --------------------------------------------------------------------------
  logic            w_tick;
  logic            w_h_wrap;
  logic [c_HW-1:0] w_h_nxt;
  logic [c_VW-1:0] w_v_nxt;
  logic [c_HW-1:0] w_h_ahead;
  logic [c_VW-1:0] w_v_ahead;
  logic            w_tile_edge;
  logic            w_ahead_edge;
  logic            w_active;
  logic [23:0]     w_colour;
  logic            w_hsync_low;
  logic            w_vsync_low;
  logic            w_inline_fetch;
  logic            w_line_fetch;
  logic [BUS-1:0]  w_addr_inline;
  logic [BUS-1:0]  w_addr_line;

  // The alpha/padding byte of each colour word carries no information here.
  logic            w_unused_rd_hi;

  assign w_tick    = (r_div == c_DIV_LAST);
  assign w_h_wrap  = (r_h == c_H_LAST);
  assign w_h_nxt   = w_h_wrap ? '0 : r_h + c_HW'(1);
  assign w_v_nxt   = w_h_wrap ? ((r_v == c_V_LAST) ? '0 : r_v + c_VW'(1)) : r_v;

  // Column one pixel ahead, and the line after the one being entered.
  assign w_h_ahead = w_h_nxt + c_HW'(1);
  assign w_v_ahead = (w_v_nxt == c_V_LAST) ? '0 : w_v_nxt + c_VW'(1);

  assign w_tile_edge  = (w_h_nxt[TILE_SHIFT-1:0] == '0);
  assign w_ahead_edge = (w_h_ahead[TILE_SHIFT-1:0] == '0);
  assign w_active     = (w_h_nxt < c_H_ACT) && (w_v_nxt < c_V_ACT);

  // The first pixel of a tile must use the freshly fetched word directly,
  // since cur_tile only takes it over on this same edge.
  assign w_colour     = w_tile_edge ? r_next_tile : r_cur_tile;

  assign w_hsync_low  = (w_h_nxt >= c_HS_BEG) && (w_h_nxt < c_HS_END);
  assign w_vsync_low  = (w_v_nxt >= c_VS_BEG) && (w_v_nxt < c_VS_END);

  // Fetch the next tile one pixel before it is needed: inside a visible line
  // when the next column starts a tile, and on the last column of a line for
  // the first tile of the following visible line.
  assign w_inline_fetch = w_ahead_edge && (w_h_ahead < c_H_ACT) && (w_v_nxt < c_V_ACT);
  assign w_line_fetch   = (w_h_nxt == c_H_LAST) && (w_v_ahead < c_V_ACT);

  assign w_addr_inline  = c_BASE + BUS'(w_v_nxt >> TILE_SHIFT) * c_TX
                          + BUS'(w_h_ahead >> TILE_SHIFT);
  assign w_addr_line    = c_BASE + BUS'(w_v_ahead >> TILE_SHIFT) * c_TX;

  assign w_unused_rd_hi = ^mem.rd_data[BUS-1:24];

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------

  // Pixel divider and raster counters; position advances only on a tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
      r_h   <= c_H_RST;
      r_v   <= c_V_LAST;
    end else if (w_tick) begin
      r_div <= '0;
      r_h   <= w_h_nxt;
      r_v   <= w_v_nxt;
    end else begin
      r_div <= r_div + c_DW'(1);
    end
  end

  // Registered pixel colour and syncs for the position being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb      <= '0;
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
      r_cur_tile <= '0;
    end else if (w_tick) begin
      r_rgb   <= w_active ? w_colour : '0;
      r_hsync <= ~w_hsync_low;
      r_vsync <= ~w_vsync_low;
      if (w_tile_edge) begin
        r_cur_tile <= r_next_tile;
      end
    end
  end

  // One-clock marker following the tick that lands on pixel (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_tick && (w_h_nxt == '0) && (w_v_nxt == '0);
    end
  end

  // Read request: a single-clock strobe, address held between requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
    end else if (w_tick && w_line_fetch) begin
      r_rd_en   <= 1'b1;
      r_rd_addr <= w_addr_line;
    end else if (w_tick && w_inline_fetch) begin
      r_rd_en   <= 1'b1;
      r_rd_addr <= w_addr_inline;
    end else begin
      r_rd_en   <= 1'b0;
    end
  end

  // Capture the memory answer on the edge after the strobe; with at least
  // two clocks per pixel this always lands before the tick that uses it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_next_tile <= '0;
    end else if (r_rd_en) begin
      r_next_tile <= mem.rd_data[23:0];
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem.rd_en   = r_rd_en;
  assign mem.rd_addr = r_rd_addr;
  assign R           = r_rgb[23:16];
  assign G           = r_rgb[15:8];
  assign B           = r_rgb[7:0];
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_frame_reader
//  Description : Scoreboard bench for vga_frame_reader. Two instances (pixel
//                divider 2 / base 0 and divider 4 / base 0x40) on a reduced
//                raster share one randomised memory image. Expected pixels
//                and fetches come from a pixel-index model of the frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_frame_reader;

  localparam int HA  = 64;
  localparam int HFP = 4;
  localparam int HSW = 8;
  localparam int HBP = 4;
  localparam int VA  = 48;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 3;
  localparam int TS  = 4;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int FR  = HT * VT;
  localparam int TX  = HA >> TS;
  localparam int NSEG = 3;

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        fe;
    logic [31:0] addr;
  } exp_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem [1024];
  int          checks = 0;
  int          errors = 0;
  int          seg_ticks = 0;
  int          seg_gen = 0;

  // Free-running clock
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int PD = (gi == 0) ? 2 : 4;
    localparam int BA = (gi == 0) ? 0 : 'h40;

    vga_frame_reader_if #(.BUS(32)) mif ();
    logic [7:0] r, g, b;
    logic       hs, vs, fs;
    exp_t       exp_q [$];
    exp_t       e;
    int         cnt = 0;
    int         tk = 0;
    int         gen_seen = 0;
    int         pend = 0;

    vga_frame_reader #(
      .BUS(32), .BASE_ADDR(BA), .PIX_DIV(PD), .TILE_SHIFT(TS),
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
    ) dut (
      .clk(clk), .reset(reset), .mem(mif),
      .R(r), .G(g), .B(b), .hsync(hs), .vsync(vs), .frame_start(fs)
    );

    // Memory answers during the strobe cycle; garbage otherwise
    assign mif.rd_data = mif.rd_en ? mem[mif.rd_addr[9:0]] : 32'hDEAD_BEEF;

    function automatic logic [31:0] taddr(int x, int y);
      return 32'(BA + (y >> TS) * TX + (x >> TS));
    endfunction

    // Tick t after reset shows linear pixel (t-1) mod FR
    function automatic exp_t ref_tick(int t);
      exp_t        ex;
      int          p, x, y, q, qx, qy;
      logic [31:0] a;
      p = (t + FR - 1) % FR;
      x = p % HT;
      y = p / HT;
      q = (p + 1) % FR;
      qx = q % HT;
      qy = q / HT;
      a = taddr(x, y);
      ex.rgb  = (x < HA && y < VA) ? mem[a[9:0]][23:0] : 24'h0;
      ex.hs   = !(x >= HA + HFP && x < HA + HFP + HSW);
      ex.vs   = !(y >= VA + VFP && y < VA + VFP + VSW);
      ex.fs   = (x == 0 && y == 0);
      ex.fe   = (qx < HA && qy < VA && (qx % (1 << TS)) == 0);
      ex.addr = taddr(qx, qy);
      return ex;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s inst%0d tick%0d: got %h, expected %h", nm, gi, tk, got, want);
      end
    endtask

    // Scoreboard: load expectations per segment, compare once per pixel tick
    always @(posedge clk) begin
      #1;
      if (gen_seen != seg_gen) begin
        gen_seen = seg_gen;
        for (int t = 0; t < seg_ticks; t++) exp_q.push_back(ref_tick(t));
      end
      if (reset) begin
        cnt = 0;
        tk  = 0;
        chk("reset_outputs", {4'h0, r, g, b, hs, vs, fs, mif.rd_en}, {4'h0, 24'h0, 4'b1100});
        chk("reset_rd_addr", mif.rd_addr, 32'h0);
      end else begin
        cnt++;
        if (exp_q.size() > 0) begin
          if (cnt % PD == 0) begin
            e = exp_q.pop_front();
            chk("rgb", {8'h0, r, g, b}, {8'h0, e.rgb});
            chk("sync_fs", {29'h0, hs, vs, fs}, {29'h0, e.hs, e.vs, e.fs});
            chk("rd_en_tick", {31'h0, mif.rd_en}, {31'h0, e.fe});
            if (e.fe) chk("rd_addr", mif.rd_addr, e.addr);
            tk++;
          end else begin
            chk("rd_en_idle", {31'h0, mif.rd_en}, 32'h0);
          end
        end
      end
      pend = exp_q.size();
    end
  end

  // Segments: randomise memory under reset, release, drain, reset mid-line
  initial begin
    for (int s = 0; s < NSEG; s++) begin
      if (s > 0) begin
        repeat ($urandom_range(300, 37)) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      if (s == 0) begin
        mem[0] = 32'h00FF_0000;
        mem[1] = 32'h0000_FF00;
      end
      seg_ticks = (s == 0) ? FR + 200 : (s == 1) ? 1500 : 900;
      seg_gen   = seg_gen + 1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      for (int k = 0; k < 100000; k++) begin
        if (g_cfg[0].pend == 0 && g_cfg[1].pend == 0) break;
        @(posedge clk);
      end
      if (g_cfg[0].pend != 0 || g_cfg[1].pend != 0) begin
        $display("FAIL drain seg%0d: pending %0d/%0d, expected 0/0",
                 s, g_cfg[0].pend, g_cfg[1].pend);
        $fatal(1, "scoreboard did not drain");
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
